// File: rtl/fe_pkg.sv
// Shared fetch-side definitions: instruction length encodings, fetch FSM states
// and the number of halfwords carried by one fetched word.
package fe_pkg;

    localparam int HW_PER_WORD = 4;

    localparam logic [1:0] INST_LEN_16 = 2'd0;
    localparam logic [1:0] INST_LEN_32 = 2'd1;
    localparam logic [1:0] INST_LEN_64 = 2'd2;

    typedef enum logic [1:0] {
        FE_S_IDLE  = 2'd0,
        FE_S_REQ   = 2'd1,
        FE_S_FLUSH = 2'd2
    } fe_state_e;

endpackage

// File: rtl/fe_len_dec.sv
// Instruction length decode from the first halfword of an instruction.
// Purely combinational; shared with the decode stage.
import fe_pkg::*;

module fe_len_dec (
    input  logic [15:0] hw,
    output logic [1:0]  inst_len,
    output logic [2:0]  hw_cnt
);

    always_comb begin
        inst_len = INST_LEN_16;
        hw_cnt   = 3'd1;
        if (hw[15]) begin
            if (hw[14]) begin
                inst_len = INST_LEN_64;
                hw_cnt   = 3'd4;
            end else begin
                inst_len = INST_LEN_32;
                hw_cnt   = 3'd2;
            end
        end
    end

endmodule

// File: rtl/fe_align_buffer.sv
// Fetch alignment buffer: fetches 64-bit words, queues halfwords and presents one
// left-justified 16/32/64b instruction to decode. FE_ALIGN_STATS_EN adds stat counters.
//
// Handshakes: imem_req/imem_addr are held stable from request until the cycle imem_ack
// is seen high (data valid with ack); decode consumes the head on inst_valid & ~stall.
import fe_pkg::*;

module fe_align_buffer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          BUF_HW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_data,
    output logic [63:0] inst,
    output logic        inst_valid,
    output logic [63:0] inst_pc,
    output logic [1:0]  inst_len,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
`ifdef FE_ALIGN_STATS_EN
    output logic [31:0] stat_inst_cnt,
    output logic [31:0] stat_starve_cnt,
`endif
    output fe_state_e   dbg_state
);

    localparam int PTR_W = $clog2(BUF_HW);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] SPACE_LIM = OCC_W'(BUF_HW - HW_PER_WORD);

    fe_state_e          state_q, state_d;
    logic [63:0]        fetch_pc_q, tgt_pc_q, head_pc_q;
    logic [15:0]        hw_q [BUF_HW];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [OCC_W-1:0]   occ_q;

    logic [15:0]        win    [HW_PER_WORD];
    logic [15:0]        dat_hw [HW_PER_WORD];
    logic [1:0]         head_len;
    logic [2:0]         head_cnt, cons_cnt, wr_cnt, wr_add;
    logic [1:0]         drop;
    logic               head_valid, consume, word_ok;
    logic [63:0]        rpc_al;

    always_comb begin
        for (int i = 0; i < HW_PER_WORD; i++) begin
            win[i]    = hw_q[rd_ptr_q + PTR_W'(i)];
            dat_hw[i] = imem_data[63 - 16*i -: 16];
        end
    end

    fe_len_dec u_len_dec (
        .hw       (win[0]),
        .inst_len (head_len),
        .hw_cnt   (head_cnt)
    );

    assign head_valid = (occ_q >= OCC_W'(head_cnt));
    assign consume    = head_valid & ~stall & ~redirect;
    assign word_ok    = imem_ack & (state_q == FE_S_REQ) & ~redirect;
    // Leading halfwords below the target PC are dropped; fetch_pc is word-aligned after the first word.
    assign drop       = fetch_pc_q[2:1];
    assign wr_cnt     = 3'(HW_PER_WORD) - {1'b0, drop};
    assign cons_cnt   = consume ? head_cnt : 3'd0;
    assign wr_add     = word_ok ? wr_cnt : 3'd0;
    assign rpc_al     = {redirect_pc[63:1], 1'b0};

    always_comb begin
        inst = 64'h0;
        if (head_valid) begin
            case (head_len)
                INST_LEN_16: inst = {win[0], 48'h0};
                INST_LEN_32: inst = {win[0], win[1], 32'h0};
                default:     inst = {win[0], win[1], win[2], win[3]};
            endcase
        end
    end

    assign inst_valid = head_valid;
    assign inst_len   = head_valid ? head_len : INST_LEN_16;
    assign inst_pc    = head_pc_q;
    assign imem_req   = (state_q != FE_S_IDLE);
    assign imem_addr  = {fetch_pc_q[63:3], 3'b000};
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FE_S_IDLE: begin
                if (redirect || occ_q <= SPACE_LIM) state_d = FE_S_REQ;
            end
            FE_S_REQ: begin
                if (redirect)      state_d = imem_ack ? FE_S_REQ : FE_S_FLUSH;
                else if (imem_ack) state_d = FE_S_IDLE;
            end
            FE_S_FLUSH: begin
                if (imem_ack) state_d = FE_S_IDLE;
            end
            default: state_d = FE_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FE_S_IDLE;
            fetch_pc_q <= {RESET_PC[63:1], 1'b0};
            tgt_pc_q   <= {RESET_PC[63:1], 1'b0};
        end else begin
            state_q <= state_d;
            if (redirect) tgt_pc_q <= rpc_al;
            // An ack that lands with the redirect completes the old request, so the new PC starts at once.
            if (redirect && (state_q == FE_S_IDLE || imem_ack))
                fetch_pc_q <= rpc_al;
            else if (state_q == FE_S_FLUSH && imem_ack)
                fetch_pc_q <= tgt_pc_q;
            else if (word_ok)
                fetch_pc_q <= {fetch_pc_q[63:3], 3'b000} + 64'd8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            head_pc_q <= {RESET_PC[63:1], 1'b0};
            for (int k = 0; k < BUF_HW; k++) hw_q[k] <= 16'h0;
        end else if (redirect) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            head_pc_q <= rpc_al;
        end else begin
            if (word_ok) begin
                for (int k = 0; k < HW_PER_WORD; k++)
                    if (k < int'(wr_cnt))
                        hw_q[wr_ptr_q + PTR_W'(k)] <= dat_hw[drop + 2'(k)];
            end
            rd_ptr_q  <= rd_ptr_q + PTR_W'(cons_cnt);
            wr_ptr_q  <= wr_ptr_q + PTR_W'(wr_add);
            occ_q     <= occ_q - OCC_W'(cons_cnt) + OCC_W'(wr_add);
            head_pc_q <= head_pc_q + (64'(cons_cnt) << 1);
        end
    end

`ifdef FE_ALIGN_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_inst_cnt   <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (consume && stat_inst_cnt != '1)
                stat_inst_cnt <= stat_inst_cnt + 32'd1;
            if (!head_valid && !stall && !redirect && stat_starve_cnt != '1)
                stat_starve_cnt <= stat_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fe_align_buffer.sv
// Directed bench for fe_align_buffer: reference instruction table plus hand-written
// sequences for spanning, stall back-pressure, redirect-in-flight, redirect-under-stall and reset.
module tb_fe_align_buffer;
    import fe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_data = 64'h0;
    logic [63:0] inst;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic [1:0]  inst_len;
    logic        stall = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    fe_state_e   dbg_state;
`ifdef FE_ALIGN_STATS_EN
    logic [31:0] stat_inst_cnt, stat_starve_cnt;
`endif

    always #5 clk = ~clk;

    fe_align_buffer #(.RESET_PC(64'h0), .BUF_HW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .inst_len    (inst_len),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FE_ALIGN_STATS_EN
        .stat_inst_cnt   (stat_inst_cnt),
        .stat_starve_cnt (stat_starve_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [63:0] mem [logic [63:0]];
    logic [63:0] hold_addr = '1;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    // Answers a request one cycle after it is seen, unless its address is held back.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (!rst && imem_req && imem_addr != hold_addr) begin
                imem_ack  = 1'b1;
                imem_data = mem_rd(imem_addr);
            end
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: inst_valid never rose within 40 cycles", name);
        end
    endtask

    task automatic wait_req(input string name, input logic [63:0] addr, input logic any_addr);
        int n = 0;
        while (!(imem_req && (any_addr || imem_addr == addr)) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!(imem_req && (any_addr || imem_addr == addr))) begin
            checks++;
            errors++;
            $display("FAIL %s: no request within 30 cycles", name);
        end
    endtask

    task automatic consume_one();
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    typedef struct {
        logic [63:0] inst;
        logic [63:0] pc;
        logic [1:0]  len;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s_inst, s_pc;
        logic        stable, req_seen;
        int          n;

        mem[64'h000] = 64'h1000_8000_2000_3000;
        mem[64'h008] = 64'hC001_0002_0003_0004;
        mem[64'h010] = 64'h0005_8006_0007_0008;
        mem[64'h200] = 64'h1000_1000_1000_C000;
        mem[64'h208] = 64'h1111_2222_3333_4444;
        mem[64'h300] = 64'h0301_0302_0303_0304;
        mem[64'h308] = 64'h0305_0306_0307_0308;
        mem[64'h400] = 64'hDEAD_BEEF_DEAD_BEEF;
        mem[64'h100] = 64'hDEAD_DEAD_0104_0106;
        mem[64'h500] = 64'h5000_5001_5002_5003;
        mem[64'h600] = 64'h0601_0602_0603_0604;

        vecs[0] = '{64'h1000_0000_0000_0000, 64'h00, 2'd0};
        vecs[1] = '{64'h8000_2000_0000_0000, 64'h02, 2'd1};
        vecs[2] = '{64'h3000_0000_0000_0000, 64'h06, 2'd0};
        vecs[3] = '{64'hC001_0002_0003_0004, 64'h08, 2'd2};
        vecs[4] = '{64'h0005_0000_0000_0000, 64'h10, 2'd0};
        vecs[5] = '{64'h8006_0007_0000_0000, 64'h12, 2'd1};
        vecs[6] = '{64'h0008_0000_0000_0000, 64'h16, 2'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   64'(imem_req), 64'h0);
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_inst",  inst, 64'h0);
        check("rst_pc",    inst_pc, 64'h0);
        check("rst_state", 64'(dbg_state), 64'(FE_S_IDLE));
        rst = 1'b0;

        // Table: in-order stream across word boundaries, all three lengths
        for (int i = 0; i < 7; i++) begin
            wait_valid($sformatf("vec%0d_wait", i));
            check($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
            check($sformatf("vec%0d_pc", i),   inst_pc, vecs[i].pc);
            check($sformatf("vec%0d_len", i),  64'(inst_len), 64'(vecs[i].len));
            consume_one();
        end

        // 64b instruction spanning two words, second word held back
        hold_addr = 64'h208;
        do_redirect(64'h206);
        repeat (8) @(negedge clk);
        check("span_valid_low", 64'(inst_valid), 64'h0);
        check("span_inst_zero", inst, 64'h0);
        check("span_pc",        inst_pc, 64'h206);
        check("span_req_addr",  imem_addr, 64'h208);
        hold_addr = '1;
        wait_valid("span_wait");
        check("span_inst", inst, 64'hC000_1111_2222_3333);
        check("span_len",  64'(inst_len), 64'(INST_LEN_64));
        consume_one();
        wait_valid("span_next_wait");
        check("span_next_inst", inst, 64'h4444_0000_0000_0000);
        check("span_next_pc",   inst_pc, 64'h20E);

        // Stall back-pressure: outputs stable, fetching stops when full
        do_redirect(64'h300);
        repeat (12) @(negedge clk);
        s_inst = inst;
        s_pc   = inst_pc;
        stable = inst_valid;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!inst_valid || inst !== s_inst || inst_pc !== s_pc) stable = 1'b0;
        end
        check("stall_stable",   64'(stable), 64'h1);
        check("stall_inst",     s_inst, 64'h0301_0000_0000_0000);
        check("stall_req_idle", 64'(imem_req), 64'h0);
        stall = 1'b0;
        repeat (4) @(negedge clk);
        stall = 1'b1;
        check("stall_rel_pc",   inst_pc, 64'h308);
        check("stall_rel_inst", inst, 64'h0305_0000_0000_0000);
        req_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) req_seen = 1'b1;
            @(negedge clk);
        end
        check("stall_rel_req", 64'(req_seen), 64'h1);

        // Redirect while a request is in flight: old data discarded
        hold_addr = 64'h400;
        do_redirect(64'h400);
        wait_req("flush_setup", 64'h400, 1'b0);
        do_redirect(64'h104);
        check("flush_state", 64'(dbg_state), 64'(FE_S_FLUSH));
        check("flush_addr",  imem_addr, 64'h400);
        check("flush_req",   64'(imem_req), 64'h1);
        check("flush_pc",    inst_pc, 64'h104);
        repeat (2) @(negedge clk);
        hold_addr = '1;
        n = 0;
        while (!(imem_req && imem_addr != 64'h400) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("flush_next_addr", imem_addr, 64'h100);
        wait_valid("flush_wait");
        check("flush_inst0", inst, 64'h0104_0000_0000_0000);
        check("flush_pc0",   inst_pc, 64'h104);
        consume_one();
        wait_valid("flush_wait1");
        check("flush_inst1", inst, 64'h0106_0000_0000_0000);
        check("flush_pc1",   inst_pc, 64'h106);

        // Redirect under stall with a valid head: nothing consumed
        do_redirect(64'h500);
        check("redir_valid_low", 64'(inst_valid), 64'h0);
        check("redir_inst_zero", inst, 64'h0);
        check("redir_pc",        inst_pc, 64'h500);
        wait_valid("redir_wait");
        check("redir_inst", inst, 64'h5000_0000_0000_0000);
        check("redir_pc2",  inst_pc, 64'h500);

        // Reset in the middle of an outstanding request
        hold_addr = 64'h608;
        do_redirect(64'h600);
        wait_req("rst_mid_setup", 64'h608, 1'b0);
        check("rst_mid_pre_valid", 64'(inst_valid), 64'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_req",   64'(imem_req), 64'h0);
        check("rst_mid_valid", 64'(inst_valid), 64'h0);
        check("rst_mid_inst",  inst, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        hold_addr = '1;
        wait_req("rst_mid_resume", 64'h0, 1'b1);
        check("rst_mid_addr", imem_addr, 64'h0);
        wait_valid("rst_mid_wait");
        check("rst_mid_inst0", inst, 64'h1000_0000_0000_0000);
        check("rst_mid_pc0",   inst_pc, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
